// File: rtl/upe_seq_nvar.sv
// Sequential uncertainty-propagation engine: var_z = sum_ij g_i*g_j*C_ij over the upper triangle.
// Optional build macro UPE_CLAMP_NEG_EN clamps a negative raw sum to zero on var_z.
module upe_seq_nvar #(
    parameter int WIDTH = 16,
    parameter int NVARS = 2,
    parameter int OUT_W = 64
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [NVARS*WIDTH-1:0]                 grad,
    input  logic [(NVARS*(NVARS+1)/2)*WIDTH-1:0]   covar,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [OUT_W-1:0]                       var_z,
    output logic                                   neg_flag
);
    localparam int P      = NVARS * (NVARS + 1) / 2;
    localparam int IW     = (NVARS > 1) ? $clog2(NVARS) : 1;
    localparam int PW     = (P > 1) ? $clog2(P) : 1;
    localparam int TW     = 3 * WIDTH + 2;
    localparam int STAGES = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                       state;
    logic [NVARS-1:0][WIDTH-1:0]  grad_q;
    logic [P-1:0][WIDTH-1:0]      covar_q;
    logic [IW-1:0]                ii, jj;
    logic [PW-1:0]                kk;
    logic [1:0]                   drain_cnt;
    logic [STAGES:0]              vld_pipe;
    logic [OUT_W-1:0]             acc;

    logic signed [WIDTH-1:0]      gi, gj;
    logic [WIDTH-1:0]             c_sel;
    logic signed [WIDTH:0]        c_ext;
    logic signed [2*WIDTH-1:0]    gg_d, gg_q;
    logic signed [WIDTH:0]        c_q;
    logic                         off_q;
    logic signed [TW-1:0]         prod, term_q;
    logic signed [OUT_W-1:0]      term_ext;

    assign gi    = grad_q[ii];
    assign gj    = grad_q[jj];
    assign c_sel = covar_q[kk];
    // Diagonal variances are unsigned, off-diagonal covariances signed.
    assign c_ext = (ii == jj) ? {1'b0, c_sel} : {c_sel[WIDTH-1], c_sel};
    assign gg_d  = gi * gj;
    assign prod  = gg_q * c_q;
    assign term_ext = OUT_W'(term_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            var_z     <= '0;
            neg_flag  <= 1'b0;
            acc       <= '0;
            ii        <= '0;
            jj        <= '0;
            kk        <= '0;
            drain_cnt <= '0;
            vld_pipe  <= '0;
            grad_q    <= '0;
            covar_q   <= '0;
            gg_q      <= '0;
            c_q       <= '0;
            off_q     <= 1'b0;
            term_q    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], (state == RUN)};
            gg_q     <= gg_d;
            c_q      <= c_ext;
            off_q    <= (ii != jj);
            // Off-diagonal entries stand for both C_ij and C_ji.
            term_q   <= off_q ? (prod <<< 1) : prod;
            if (vld_pipe[STAGES])
                acc <= acc + term_ext;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        grad_q   <= grad;
                        covar_q  <= covar;
                        acc      <= '0;
                        ii       <= '0;
                        jj       <= '0;
                        kk       <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    kk <= kk + 1'b1;
                    if (jj == IW'(NVARS - 1)) begin
                        ii <= ii + 1'b1;
                        jj <= ii + 1'b1;
                    end else begin
                        jj <= jj + 1'b1;
                    end
                    if (kk == PW'(P - 1)) begin
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Two pipe stages plus the accumulate must settle before acc is final.
                    if (drain_cnt == 2'd2) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        neg_flag  <= acc[OUT_W-1];
`ifdef UPE_CLAMP_NEG_EN
                        var_z     <= acc[OUT_W-1] ? '0 : acc;
`else
                        var_z     <= acc;
`endif
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_upe_seq_nvar.sv
// Directed bench for upe_seq_nvar: NVARS=2 main instance plus an NVARS=1 instance.
module tb_upe_seq_nvar;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, out_valid, out_ready, neg_flag;
    logic [31:0] grad;
    logic [47:0] covar;
    logic [63:0] var_z;

    logic        in_valid1, in_ready1, out_valid1, out_ready1, neg_flag1;
    logic [15:0] grad1, covar1;
    logic [63:0] var_z1;

    int total = 0;
    int bad   = 0;

    upe_seq_nvar #(.WIDTH(16), .NVARS(2), .OUT_W(64)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .grad(grad), .covar(covar), .out_valid(out_valid), .out_ready(out_ready),
        .var_z(var_z), .neg_flag(neg_flag)
    );

    upe_seq_nvar #(.WIDTH(16), .NVARS(1), .OUT_W(64)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .grad(grad1), .covar(covar1), .out_valid(out_valid1), .out_ready(out_ready1),
        .var_z(var_z1), .neg_flag(neg_flag1)
    );

    // Present a request, hold until accepted, then scramble the inputs.
    task automatic issue(input logic [31:0] g, input logic [47:0] c);
        @(negedge clk);
        grad = g; covar = c; in_valid = 1'b1;
        for (int n = 0; n < 40 && !in_ready; n++) @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        grad  = 32'hA5A5_5A5A;
        covar = 48'h1234_5678_9ABC;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 30);
    endtask

    task automatic handshake();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; grad = '0; covar = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; grad1 = '0; covar1 = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (var_z !== 64'd0)    begin bad++; $display("FAIL rst_var_z got=%h exp=0", var_z); end
        total++; if (neg_flag !== 1'b0)  begin bad++; $display("FAIL rst_neg_flag got=%b exp=0", neg_flag); end
        total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL rst_in_ready1 got=%b exp=1", in_ready1); end
        total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL rst_out_valid1 got=%b exp=0", out_valid1); end
        rst = 1'b0;
    endtask

    task automatic test_vec(input string name, input logic [31:0] g, input logic [47:0] c,
                            input logic [63:0] exp_v, input logic exp_n);
        int lat;
        issue(g, c);
        wait_out(lat);
        total++; if (lat !== 6)        begin bad++; $display("FAIL %s_latency got=%0d exp=6", name, lat); end
        total++; if (var_z !== exp_v)  begin bad++; $display("FAIL %s_var_z got=%h exp=%h", name, var_z, exp_v); end
        total++; if (neg_flag !== exp_n) begin bad++; $display("FAIL %s_neg got=%b exp=%b", name, neg_flag, exp_n); end
        handshake();
    endtask

    task automatic test_hold();
        int lat;
        issue({16'hFFFE, 16'd3}, {16'd9, 16'd0, 16'd4});
        wait_out(lat);
        total++; if (lat !== 6) begin bad++; $display("FAIL hold_latency got=%0d exp=6", lat); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                grad = {16'd2, 16'd3}; covar = {16'd9, 16'hFFFB, 16'd4}; in_valid = 1'b1;
            end
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_out_valid cyc=%0d got=%b exp=1", i, out_valid); end
            total++; if (var_z !== 64'd72)   begin bad++; $display("FAIL hold_var_z cyc=%0d got=%h exp=48", i, var_z); end
            total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_hs_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL hold_hs_in_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; grad = '1; covar = '1;
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL hold_second_accept got=%b exp=0", in_ready); end
        wait_out(lat);
        total++; if (lat !== 6)          begin bad++; $display("FAIL hold_second_latency got=%0d exp=6", lat); end
        total++; if (var_z !== 64'd12)   begin bad++; $display("FAIL hold_second_var_z got=%h exp=c", var_z); end
        handshake();
    endtask

    task automatic test_ready_early();
        int lat;
        @(negedge clk); out_ready = 1'b1;
        issue({16'd2, 16'd3}, {16'd9, 16'hFFFB, 16'd4});
        wait_out(lat);
        total++; if (lat !== 6)        begin bad++; $display("FAIL early_latency got=%0d exp=6", lat); end
        total++; if (var_z !== 64'd12) begin bad++; $display("FAIL early_var_z got=%h exp=c", var_z); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL early_one_cycle got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL early_in_ready got=%b exp=1", in_ready); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        issue({16'hFFFE, 16'd3}, {16'd9, 16'd0, 16'd4});
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        seen = 0;
        repeat (8) begin @(posedge clk); #1; if (out_valid) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_emit got=%0d exp=0", seen); end
        test_vec("midrst_retry", {16'hFFFE, 16'd3}, {16'd9, 16'd0, 16'd4}, 64'd72, 1'b0);
    endtask

    task automatic test_nvar1();
        int lat;
        @(negedge clk);
        grad1 = 16'h8000; covar1 = 16'hFFFF; in_valid1 = 1'b1;
        for (int n = 0; n < 40 && !in_ready1; n++) @(negedge clk);
        @(posedge clk); #1;
        in_valid1 = 1'b0; grad1 = 16'h1111; covar1 = 16'h2222;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!out_valid1 && lat < 30);
        total++; if (lat !== 4) begin bad++; $display("FAIL nvar1_latency got=%0d exp=4", lat); end
        total++; if (var_z1 !== 64'h0000_3FFF_C000_0000)
            begin bad++; $display("FAIL nvar1_var_z got=%h exp=00003fffc0000000", var_z1); end
        total++; if (neg_flag1 !== 1'b0) begin bad++; $display("FAIL nvar1_neg got=%b exp=0", neg_flag1); end
        @(negedge clk); out_ready1 = 1'b1;
        @(posedge clk); #1; out_ready1 = 1'b0;
        total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL nvar1_hs got=%b exp=0", out_valid1); end
    endtask

    initial begin
        logic [63:0] exp_neg;
`ifdef UPE_CLAMP_NEG_EN
        exp_neg = 64'd0;
`else
        exp_neg = 64'hFFFF_FFFF_FFFF_FFEE;
`endif
        test_reset();
        test_vec("basic",   {16'hFFFE, 16'd3}, {16'd9, 16'd0, 16'd4},     64'd72, 1'b0);
        test_vec("offdiag", {16'd2, 16'd3},    {16'd9, 16'hFFFB, 16'd4},  64'd12, 1'b0);
        test_vec("negsum",  {16'd1, 16'd1},    {16'd1, 16'hFFF6, 16'd1},  exp_neg, 1'b1);
        test_hold();
        test_ready_early();
        test_reset_mid();
        test_nvar1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
